// File: rtl/elevator_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module      : elevator_ctrl_n
// Description : N-floor SCAN elevator controller paced by a timebase strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_ctrl_n #(
    parameter int FLOORS       = 4,
    parameter int FLOOR_W      = 2,
    parameter int TRAVEL_TICKS = 8,
    parameter int DOOR_TICKS   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               stop,
    input  logic [FLOORS-1:0]  req,
    output logic [FLOOR_W-1:0] level,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic [FLOORS-1:0]  pending,
    output logic               arrive
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_move = 2'd1;
    localparam logic [1:0] c_st_door = 2'd2;

    localparam logic [7:0] c_travel_last = 8'(TRAVEL_TICKS - 1);
    localparam logic [7:0] c_door_last   = 8'(DOOR_TICKS - 1);

    logic [1:0]         r_state;
    logic [FLOOR_W-1:0] r_level;
    logic               r_dir_up;
    logic               r_moving;
    logic               r_door_open;
    logic               r_arrive;
    logic [FLOORS-1:0]  r_pending;
    logic [7:0]         r_travel_cnt;
    logic [7:0]         r_door_cnt;

    logic [FLOORS-1:0]  w_eff;
    logic [FLOORS-1:0]  w_level_oh;
    logic [FLOORS-1:0]  w_next_oh;
    logic [FLOOR_W-1:0] w_next_level;
    logic               w_any_above;
    logic               w_any_below;
    logic               w_here;
    logic               w_hit_next;
    logic               w_step;

    logic [1:0]         w_state_nxt;
    logic [FLOOR_W-1:0] w_level_nxt;
    logic               w_dir_nxt;
    logic               w_arrive_nxt;
    logic [7:0]         w_travel_nxt;
    logic [7:0]         w_door_nxt;
    logic [FLOORS-1:0]  w_clear;

    // Decisions look at pending OR'ed with this cycle's requests.
    always_comb begin
        w_eff        = r_pending | req;
        w_step       = tick & ~stop;
        w_next_level = r_dir_up ? (r_level + 1'b1) : (r_level - 1'b1);
        w_any_above  = 1'b0;
        w_any_below  = 1'b0;
        w_level_oh   = '0;
        w_next_oh    = '0;
        for (int i = 0; i < FLOORS; i++) begin
            w_level_oh[i] = (i == int'(r_level));
            w_next_oh[i]  = (i == int'(w_next_level));
            if (w_eff[i] && (i > int'(r_level))) w_any_above = 1'b1;
            if (w_eff[i] && (i < int'(r_level))) w_any_below = 1'b1;
        end
        w_here     = |(w_eff & w_level_oh);
        w_hit_next = |(w_eff & w_next_oh);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_level_nxt  = r_level;
        w_dir_nxt    = r_dir_up;
        w_arrive_nxt = 1'b0;
        w_travel_nxt = r_travel_cnt;
        w_door_nxt   = r_door_cnt;
        w_clear      = '0;
        case (r_state)
            c_st_idle: begin
                if (w_here) begin
                    w_state_nxt  = c_st_door;
                    w_arrive_nxt = 1'b1;
                    w_door_nxt   = 8'd0;
                    w_clear      = w_level_oh;
                end else if (w_any_above || w_any_below) begin
                    w_state_nxt  = c_st_move;
                    w_travel_nxt = 8'd0;
                    // Reverse only when nothing remains ahead.
                    if (r_dir_up && !w_any_above)
                        w_dir_nxt = 1'b0;
                    else if (!r_dir_up && !w_any_below)
                        w_dir_nxt = 1'b1;
                end
            end
            c_st_move: begin
                if (w_step) begin
                    if (r_travel_cnt == c_travel_last) begin
                        w_travel_nxt = 8'd0;
                        w_level_nxt  = w_next_level;
                        if (w_hit_next) begin
                            w_state_nxt  = c_st_door;
                            w_arrive_nxt = 1'b1;
                            w_door_nxt   = 8'd0;
                            w_clear      = w_next_oh;
                        end
                    end else begin
                        w_travel_nxt = r_travel_cnt + 8'd1;
                    end
                end
            end
            c_st_door: begin
                // A call for this floor while open is absorbed and re-arms the door.
                if (w_here) begin
                    w_door_nxt = 8'd0;
                    w_clear    = w_level_oh;
                end else if (w_step) begin
                    if (r_door_cnt == c_door_last) begin
                        w_state_nxt = c_st_idle;
                        w_door_nxt  = 8'd0;
                    end else begin
                        w_door_nxt = r_door_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_level      <= '0;
            r_dir_up     <= 1'b1;
            r_moving     <= 1'b0;
            r_door_open  <= 1'b0;
            r_arrive     <= 1'b0;
            r_pending    <= '0;
            r_travel_cnt <= 8'd0;
            r_door_cnt   <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_dir_up     <= w_dir_nxt;
            r_moving     <= (w_state_nxt == c_st_move);
            r_door_open  <= (w_state_nxt == c_st_door);
            r_arrive     <= w_arrive_nxt;
            r_pending    <= w_eff & ~w_clear;
            r_travel_cnt <= w_travel_nxt;
            r_door_cnt   <= w_door_nxt;
        end
    end

    assign level     = r_level;
    assign dir_up    = r_dir_up;
    assign moving    = r_moving;
    assign door_open = r_door_open;
    assign pending   = r_pending;
    assign arrive    = r_arrive;

endmodule
`default_nettype wire
